// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_rate_decoder
// Purpose  : Converts a single-bit spike stream into a spike-rate value by
//            counting rising edges over a fixed window of WINDOW clock cycles.
//            At each window close the count is latched onto rate_out with a
//            one-cycle rate_valid strobe. Also tracks whether the closing
//            window overflowed the output range and the peak rate seen since
//            reset or clear.
// Ports    : clk        - clock, single domain
//            rst_n      - asynchronous active-low reset
//            ena        - count enable; low freezes window and accumulator
//            clear      - synchronous soft clear of window/acc/peak/saturation
//            spike_in   - spike line, synchronous to clk
//            rate_out   - spike count of the last completed window (clipped)
//            rate_valid - one-cycle strobe, new rate_out present
//            saturated  - last completed window exceeded 2^COUNT_W-1
//            peak_rate  - maximum rate_out since reset or clear
// Revision : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
    parameter logic [23:0] WINDOW  = 24'd10_000_000,
    parameter int          COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               clear,
    input  logic               spike_in,
    output logic [COUNT_W-1:0] rate_out,
    output logic               rate_valid,
    output logic               saturated,
    output logic [COUNT_W-1:0] peak_rate
);

    localparam logic [23:0]        c_LAST     = WINDOW - 24'd1;
    // Accumulator ceiling: one past the largest representable rate, so the
    // accumulator can still tell "exactly full" from "overflowed".
    localparam logic [COUNT_W:0]   c_ACC_CAP  = {1'b1, {COUNT_W{1'b0}}};
    localparam logic [COUNT_W-1:0] c_RATE_MAX = {COUNT_W{1'b1}};

    logic               r_spike_d;
    logic [23:0]        r_win_cnt;
    logic [COUNT_W:0]   r_acc;
    logic [COUNT_W-1:0] r_rate;
    logic               r_valid;
    logic               r_sat;
    logic [COUNT_W-1:0] r_peak;

    logic               w_edge;
    logic               w_terminal;
    logic [COUNT_W:0]   w_sum;
    logic               w_over;
    logic [COUNT_W-1:0] w_clip;
    logic [COUNT_W-1:0] w_peak_next;

    assign w_edge     = spike_in & ~r_spike_d;
    assign w_terminal = ena && (r_win_cnt == c_LAST);

    // Includes the current-cycle edge so an edge on the terminal cycle is
    // credited to the closing window. Cannot wrap: max is c_ACC_CAP + 1.
    assign w_sum       = r_acc + {{COUNT_W{1'b0}}, w_edge};
    assign w_over      = (w_sum >= c_ACC_CAP);
    assign w_clip      = w_over ? c_RATE_MAX : w_sum[COUNT_W-1:0];
    assign w_peak_next = (w_clip > r_peak) ? w_clip : r_peak;

    // Edge-detect history runs every cycle, independent of ena and clear,
    // so a spike already high when counting resumes is not seen as new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spike_d <= 1'b0;
        end else begin
            r_spike_d <= spike_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= 24'd0;
            r_acc     <= '0;
            r_rate    <= '0;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            r_peak    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (clear) begin
                // Clear wins over a coincident terminal cycle; rate_out is
                // intentionally left holding its last value.
                r_win_cnt <= 24'd0;
                r_acc     <= '0;
                r_sat     <= 1'b0;
                r_peak    <= '0;
            end else if (ena) begin
                if (w_terminal) begin
                    r_rate    <= w_clip;
                    r_sat     <= w_over;
                    r_peak    <= w_peak_next;
                    r_valid   <= 1'b1;
                    r_acc     <= '0;
                    r_win_cnt <= 24'd0;
                end else begin
                    r_win_cnt <= r_win_cnt + 24'd1;
                    r_acc     <= w_over ? c_ACC_CAP : w_sum;
                end
            end
        end
    end

    assign rate_out   = r_rate;
    assign rate_valid = r_valid;
    assign saturated  = r_sat;
    assign peak_rate  = r_peak;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_rate_decoder
// Purpose  : Self-checking bench for spike_rate_decoder. Two instances share
//            the same stimulus: WINDOW=8 with COUNT_W=8 and with COUNT_W=2.
//            A reference model counts rising edges per window with plain
//            integers and clips only when a window closes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_rate_decoder;

    localparam int c_WIN = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ena      = 1'b0;
    logic       clear    = 1'b0;
    logic       spike_in = 1'b0;

    logic [7:0] rate8, peak8;
    logic       val8, sat8;
    logic [1:0] rate2, peak2;
    logic       val2, sat2;

    spike_rate_decoder #(.WINDOW(24'd8), .COUNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike_in(spike_in),
        .rate_out(rate8), .rate_valid(val8), .saturated(sat8), .peak_rate(peak8)
    );

    spike_rate_decoder #(.WINDOW(24'd8), .COUNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .spike_in(spike_in),
        .rate_out(rate2), .rate_valid(val2), .saturated(sat2), .peak_rate(peak2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (index 0: COUNT_W=8, index 1: COUNT_W=2)
    int m_win   = 0;
    int m_cnt   = 0;
    bit m_prev  = 1'b0;
    bit m_valid = 1'b0;
    int m_rate [2];
    int m_peak [2];
    bit m_sat  [2];

    function automatic int rate_max(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    task automatic model_reset();
        m_win = 0; m_cnt = 0; m_prev = 1'b0; m_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rate[k] = 0; m_peak[k] = 0; m_sat[k] = 1'b0;
        end
    endtask

    // One rising clock edge worth of behaviour, using the sampled inputs.
    task automatic model_edge();
        bit e;
        int r;
        e = spike_in && !m_prev;
        m_valid = 1'b0;
        if (clear) begin
            m_win = 0; m_cnt = 0;
            for (int k = 0; k < 2; k++) begin
                m_peak[k] = 0; m_sat[k] = 1'b0;
            end
        end else if (ena) begin
            m_cnt = m_cnt + int'(e);
            m_win = m_win + 1;
            if (m_win == c_WIN) begin
                for (int k = 0; k < 2; k++) begin
                    r = (m_cnt > rate_max(k)) ? rate_max(k) : m_cnt;
                    m_rate[k] = r;
                    m_sat[k]  = (m_cnt > rate_max(k));
                    if (r > m_peak[k]) m_peak[k] = r;
                end
                m_valid = 1'b1;
                m_win = 0; m_cnt = 0;
            end
        end
        m_prev = spike_in;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rate8",  {1'b0, rate8},      9'(m_rate[0]));
        chk("valid8", {8'd0, val8},       9'(m_valid));
        chk("sat8",   {8'd0, sat8},       9'(m_sat[0]));
        chk("peak8",  {1'b0, peak8},      9'(m_peak[0]));
        chk("rate2",  {7'd0, rate2},      9'(m_rate[1]));
        chk("valid2", {8'd0, val2},       9'(m_valid));
        chk("sat2",   {8'd0, sat2},       9'(m_sat[1]));
        chk("peak2",  {7'd0, peak2},      9'(m_peak[1]));
    endtask

    // Drive inputs just after an edge, take the next edge, then check.
    task automatic cyc(input bit e, input bit c, input bit s);
        ena = e; clear = c; spike_in = s;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();

        // Reset state
        #1;
        check_all();
        #1 rst_n = 1'b1;

        // Basic count: spikes at cycles 1, 3, 5; close on edge 8
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 1 || i == 3 || i == 5));
        chk("basic_rate", {1'b0, rate8}, 9'd3);
        chk("basic_valid", {8'd0, val8}, 9'd1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("basic_strobe_once", {8'd0, val8}, 9'd0);
        for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);

        // Held spike (counts once) plus an edge on the terminal cycle
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i <= 4 || i == 7));
        chk("held_rate", {1'b0, rate8}, 9'd2);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("empty_rate", {1'b0, rate8}, 9'd0);

        // Saturation: toggling spike gives 4 edges
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, i[0]);
        chk("sat_rate2", {7'd0, rate2}, 9'd3);
        chk("sat_flag2", {8'd0, sat2}, 9'd1);
        chk("sat_rate8", {1'b0, rate8}, 9'd4);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 3));
        chk("post_sat_rate2", {7'd0, rate2}, 9'd1);
        chk("post_sat_flag2", {8'd0, sat2}, 9'd0);
        chk("post_sat_peak2", {7'd0, peak2}, 9'd3);

        // Enable freeze mid-window with spikes in the gap
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, (i == 1));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, i[0]);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, (i == 2));
        chk("freeze_rate", {1'b0, rate8}, 9'd2);
        chk("freeze_valid", {8'd0, val8}, 9'd1);

        // Clear on the terminal cycle of a 4-spike window
        for (int i = 0; i < 8; i++) cyc(1'b1, (i == 7), (i == 0 || i == 2 || i == 4 || i == 6));
        chk("clr_valid", {8'd0, val8}, 9'd0);
        chk("clr_rate_kept", {1'b0, rate8}, 9'd2);
        chk("clr_peak", {1'b0, peak8}, 9'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 1));
        chk("clr_next_close", {8'd0, val8}, 9'd1);

        // Asynchronous reset between edges after 2 spikes
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, (i == 0 || i == 2));
        spike_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, (i == 5));
        chk("rst_first_close", {8'd0, val8}, 9'd1);
        chk("rst_rate", {1'b0, rate8}, 9'd1);

        // Clear while disabled
        cyc(1'b0, 1'b1, 1'b1);
        chk("clr_dis_peak", {1'b0, peak8}, 9'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
